// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative radix-2 MULT/MULTU/DIV/DIVU with architectural HI/LO registers.
// Magnitudes are processed unsigned over WIDTH steps and sign-corrected in FIX.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
    state_t             r_state;
    logic               r_div, r_sign_q, r_sign_r, r_dz, r_busy, r_done;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH-1:0]   r_a, r_b, r_q, r_rem, r_hi, r_lo;
    logic               w_signed;
    logic [WIDTH-1:0]   w_mag_a, w_mag_b, w_quo, w_rmd;
    logic [WIDTH:0]     w_sum, w_shift;
    logic [WIDTH+1:0]   w_diff;
    logic [2*WIDTH-1:0] w_prod, w_prod_fix;
    assign w_signed = ~op[0];
    assign w_mag_a  = (w_signed & A[WIDTH-1]) ? -A : A;
    assign w_mag_b  = (w_signed & B[WIDTH-1]) ? -B : B;
    // multiply: {r_rem, r_q} is the accumulator with the multiplier shifting out of r_q
    assign w_sum    = {1'b0, r_rem} + {1'b0, r_q[0] ? r_a : {WIDTH{1'b0}}};
    // divide: r_q shifts the dividend out and the quotient in; r_rem is the partial remainder
    assign w_shift  = {r_rem, r_q[WIDTH-1]};
    assign w_diff   = {1'b0, w_shift} - {2'b00, r_b};
    assign w_prod   = {r_rem, r_q};
    assign w_prod_fix = r_sign_q ? -w_prod : w_prod;
    // a zero divisor leaves an all-ones quotient that must not be negated
    assign w_quo    = (r_sign_q & ~r_dz) ? -r_q : r_q;
    assign w_rmd    = r_sign_r ? -r_rem : r_rem;
    assign busy = r_busy;
    assign done = r_done;
    assign HI   = r_hi;
    assign LO   = r_lo;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_div    <= 1'b0;
            r_sign_q <= 1'b0;
            r_sign_r <= 1'b0;
            r_dz     <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_q      <= '0;
            r_rem    <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_div    <= op[1];
                        r_sign_q <= w_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
                        r_sign_r <= w_signed & A[WIDTH-1];
                        r_dz     <= (B == '0);
                        r_a      <= w_mag_a;
                        r_b      <= w_mag_b;
                        r_q      <= op[1] ? w_mag_a : w_mag_b;
                        r_rem    <= '0;
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= CALC;
                    end else begin
                        if (hi_we) r_hi <= wdata;
                        if (lo_we) r_lo <= wdata;
                    end
                end
                CALC: begin
                    if (r_div) begin
                        r_rem <= w_diff[WIDTH+1] ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
                        r_q   <= {r_q[WIDTH-2:0], ~w_diff[WIDTH+1]};
                    end else begin
                        r_rem <= w_sum[WIDTH:1];
                        r_q   <= {w_sum[0], r_q[WIDTH-1:1]};
                    end
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CW'(WIDTH-1)) r_state <= FIX;
                end
                FIX: begin
                    r_hi    <= r_div ? w_rmd : w_prod_fix[2*WIDTH-1:WIDTH];
                    r_lo    <= r_div ? w_quo : w_prod_fix[WIDTH-1:0];
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: random and directed MULT/DIV/MTHI/MTLO checks against an arithmetic reference model.
module tb_muldiv_unit;
    logic        clk = 1'b0, reset = 1'b0, start = 1'b0, hi_we = 1'b0, lo_we = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [31:0] A = '0, B = '0, wdata = '0;
    logic        busy, done;
    logic [31:0] HI, LO;
    int          n_chk = 0, n_fail = 0;
    logic [31:0] exp_hi, exp_lo, hold_hi, hold_lo;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] h, output logic [31:0] l);
        longint      sa, sb;
        logic [63:0] p;
        int          qs, rs;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = 64'(sa * sb);
        if (o == 2'd1) p = {32'd0, a} * {32'd0, b};
        {h, l} = p;
        if (o[1]) begin
            if (b == 0) begin
                h = a;
                l = 32'hFFFF_FFFF;
            end else if (o == 2'd3) begin
                h = a % b;
                l = a / b;
            end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                h = 32'd0;
                l = 32'h8000_0000;
            end else begin
                qs = $signed(a) / $signed(b);
                rs = $signed(a) % $signed(b);
                h = 32'(rs);
                l = 32'(qs);
            end
        end
    endtask

    task automatic wait_done(output int e, output bit bok);
        e = 0;
        bok = busy;
        while (!done && e < 40) begin
            @(negedge clk);
            e++;
            if (!done && !busy) bok = 1'b0;
            if (e == 5) begin
                A = $urandom;
                B = $urandom;
            end
        end
    endtask

    task automatic run(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input string tag);
        int e;
        bit bok;
        model(o, a, b, exp_hi, exp_lo);
        @(negedge clk);
        op = o; A = a; B = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0; A = $urandom; B = $urandom;
        wait_done(e, bok);
        chk({tag, " latency"}, 64'(e), 64'd33);
        chk({tag, " busy_held"}, 64'(bok), 64'd1);
        chk({tag, " busy_at_done"}, 64'(busy), 64'd0);
        chk({tag, " HI"}, 64'(HI), 64'(exp_hi));
        chk({tag, " LO"}, 64'(LO), 64'(exp_lo));
        @(negedge clk);
        chk({tag, " done_width"}, 64'(done), 64'd0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20)) - 32'd10;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int e, pulses;
        bit bok;
        #3;
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        chk("reset HI", 64'(HI), 64'd0);
        chk("reset LO", 64'(LO), 64'd0);
        #20;
        @(negedge clk) reset = 1'b1;

        run(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
        run(2'd0, 32'hFFFF_FFFD, 32'd7, "mult_neg3x7");
        run(2'd0, 32'h8000_0000, 32'h8000_0000, "mult_min_sq");
        run(2'd2, 32'hFFFF_FFF9, 32'd2, "div_neg7_2");
        run(2'd3, 32'd100, 32'd7, "divu_100_7");
        run(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, "div_overflow");
        run(2'd3, 32'd5, 32'd0, "divu_by0");
        run(2'd2, 32'hFFFF_FFFB, 32'd0, "div_neg_by0");
        run(2'd2, 32'd7, 32'hFFFF_FFFE, "div_7_neg2");
        for (int i = 0; i < 40; i++) run(2'($urandom_range(0, 3)), pick(), pick(), "random");

        @(negedge clk);
        hold_lo = LO; wdata = 32'h1234_5678; hi_we = 1'b1;
        @(negedge clk);
        hi_we = 1'b0;
        chk("mthi HI", 64'(HI), 64'h1234_5678);
        chk("mthi LO_kept", 64'(LO), 64'(hold_lo));
        wdata = 32'h0BAD_F00D; hi_we = 1'b1; lo_we = 1'b1;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b0;
        chk("mthilo HI", 64'(HI), 64'h0BAD_F00D);
        chk("mthilo LO", 64'(LO), 64'h0BAD_F00D);

        hold_hi = HI; hold_lo = LO;
        op = 2'd1; A = 32'd3; B = 32'd5; start = 1'b1; hi_we = 1'b1; wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        start = 1'b0; hi_we = 1'b0;
        chk("start_wins HI", 64'(HI), 64'(hold_hi));
        repeat (5) @(negedge clk);
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hCAFE_F00D;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b0;
        chk("mid_calc HI", 64'(HI), 64'(hold_hi));
        chk("mid_calc LO", 64'(LO), 64'(hold_lo));
        op = 2'd0; A = 32'd7; B = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(e, bok);
        chk("restart latency", 64'(e), 64'd26);
        chk("restart HI", 64'(HI), 64'd0);
        chk("restart LO", 64'(LO), 64'd15);
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) pulses++;
        end
        chk("restart extra_done", 64'(pulses), 64'd0);
        chk("restart idle_busy", 64'(busy), 64'd0);

        op = 2'd1; A = 32'hFFFF_FFFF; B = 32'hFFFF_FFFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("async_rst busy", 64'(busy), 64'd0);
        chk("async_rst done", 64'(done), 64'd0);
        chk("async_rst HI", 64'(HI), 64'd0);
        chk("async_rst LO", 64'(LO), 64'd0);
        @(negedge clk) reset = 1'b1;
        run(2'd1, 32'd3, 32'd5, "post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit that sits beside the single-cycle ALU in the execute stage.
- Takes the same A/B operands from the register-file read ports. Holds the architectural HI/LO registers.
- Serves MULT/MULTU/DIV/DIVU, MTHI/MTLO and MFHI/MFLO.
- Asserts busy so the control unit stalls the PC while an operation is in flight.

Parameters:
WIDTH, 32, operand width; latency is WIDTH+1 cycles.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  launch operation; sampled only when busy=0
op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
A  input  WIDTH  multiplicand / dividend (rs)
B  input  WIDTH  multiplier / divisor (rt)
hi_we  input  1  MTHI write enable
lo_we  input  1  MTLO write enable
wdata  input  WIDTH  MTHI/MTLO data (rs)
busy  output  1  operation in flight
done  output  1  one-cycle pulse; HI/LO hold the new result
HI  output  WIDTH  HI register (product high / remainder)
LO  output  WIDTH  LO register (product low / quotient)

Behaviour:
- Reset (reset=0, asynchronous) forces the following, with no wait for clk:
  - state=IDLE, HI=0, LO=0, busy=0, done=0, counter=0.
  - Any operation in progress is discarded.
- FSM states: IDLE, CALC, FIX.
  - IDLE: at an edge with start=1, latch op and the operand magnitudes.
    - Magnitude = |x| when op[0]=0 (signed), otherwise the raw value.
    - Latch the result signs: sign_q = A[31]^B[31]; sign_r = A[31]; both valid only when signed.
    - Clear counter, go to CALC.
  - CALC: one radix-2 step per cycle; counter increments. After WIDTH steps (counter==WIDTH-1 at the edge), go to FIX.
    - Multiply: shift-add into a 2*WIDTH accumulator.
    - Divide: restoring shift-subtract. Remainder is WIDTH+1 bits internally.
  - FIX: apply sign correction (two's-complement negate). At the FIX edge, write HI/LO, register done=1 and busy=0, return to IDLE.
    - Multiply signed: negate the 2*WIDTH product if sign_q.
    - Divide signed: negate the quotient if sign_q; negate the remainder if sign_r.
- Timing: with start sampled at edge n, busy is registered high from edge n to edge n+WIDTH+1.
  - HI/LO and done are valid after edge n+WIDTH+1, i.e. 33 cycles for WIDTH=32.
  - done is high for exactly one cycle.
- busy is registered.
  - It rises after the start edge, not combinationally.
  - The control unit must also stall on (start & ~busy) in the issue cycle.
- start while busy=1 is ignored. No queueing.
- MTHI/MTLO:
  - With hi_we/lo_we=1, busy=0 and start=0, HI/LO takes wdata at the next edge.
  - Writes are ignored while busy=1 or start=1; start wins.
  - hi_we and lo_we may be asserted together.
- Divide by zero completes in the normal latency with:
  - LO = all ones;
  - HI = A as presented; for the signed case this is the dividend with its original sign, i.e. the remainder rule still holds.
- Signed overflow: 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0. This falls out of the magnitude path and needs no special case.
- HI/LO are stable except at a FIX edge, a permitted MTHI/MTLO edge, or reset.
- Operands are captured at start. A/B may change during CALC with no effect.

Test Plan:
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → 33 cycles after start: HI=0xFFFFFFFE, LO=0x00000001, done pulse 1 cycle, busy high 33 cycles.
- MULT 0xFFFFFFFD(-3) × 7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB; MULT 0x80000000 × 0x80000000 → HI=0x40000000, LO=0.
- DIV -7 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 100 / 7 → LO=14, HI=2. DIV 0x80000000 / -1 → LO=0x80000000, HI=0. DIVU 5 / 0 → LO=0xFFFFFFFF, HI=5.
- MTHI 0x12345678 while idle → HI updates next edge. Repeat mid-CALC → HI unchanged until FIX. Second start pulsed during CALC → ignored, only one done.
- Drop reset to 0 at CALC step 10, between edges → busy=0, HI=LO=0 immediately. After release, a new MULTU 3×5 gives LO=15, HI=0 in 33 cycles.
